// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register built as a 2-entry skid buffer; optional MEM_WB_STAGE_R0_FILTER_EN drops writes to r0.
// Latency: one cycle from push into an empty stage to out_valid.
// Backpressure: in_ready is registered (occupancy < 2) and never depends combinationally on out_ready.
module mem_wb_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_mem_data,
  input  logic [DATA_WIDTH-1:0]     in_alu_result,
  input  logic [REG_ADDR_WIDTH-1:0] in_reg_dest,
  input  logic                      in_reg_write,
  input  logic                      in_mem_to_reg,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_mem_data,
  output logic [DATA_WIDTH-1:0]     out_alu_result,
  output logic [REG_ADDR_WIDTH-1:0] out_reg_dest,
  output logic                      out_reg_write,
  output logic                      out_mem_to_reg,
  output logic [DATA_WIDTH-1:0]     wb_data,
  output logic [1:0]                occupancy
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     mem_data;
    logic [DATA_WIDTH-1:0]     alu_result;
    logic [REG_ADDR_WIDTH-1:0] reg_dest;
    logic                      reg_write;
    logic                      mem_to_reg;
  } payload_t;

  payload_t   head_q, head_d, skid_q, skid_d, in_beat;
  logic [1:0] occ_q, occ_d;
  logic       in_ready_q, in_ready_d;
  logic       push, pop;

  always_comb begin
    in_beat.mem_data   = in_mem_data;
    in_beat.alu_result = in_alu_result;
    in_beat.reg_dest   = in_reg_dest;
    in_beat.mem_to_reg = in_mem_to_reg;
`ifdef MEM_WB_STAGE_R0_FILTER_EN
    in_beat.reg_write  = in_reg_write && (in_reg_dest != '0);
`else
    in_beat.reg_write  = in_reg_write;
`endif
  end

  assign push = in_valid && in_ready_q;
  assign pop  = (occ_q != 2'd0) && out_ready;

  // An empty head is kept zeroed so a stale entry can never assert reg_write.
  always_comb begin
    head_d = head_q;
    skid_d = skid_q;
    occ_d  = occ_q;
    if (flush) begin
      head_d = '0;
      skid_d = '0;
      occ_d  = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ_q == 2'd0) head_d = in_beat;
          else               skid_d = in_beat;
          occ_d = occ_q + 2'd1;
        end
        2'b01: begin
          if (occ_q == 2'd2) head_d = skid_q;
          else               head_d = '0;
          occ_d = occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd2) begin
            head_d = skid_q;
            skid_d = in_beat;
          end else begin
            head_d = in_beat;
          end
        end
        default: ;
      endcase
    end
    in_ready_d = (occ_d != 2'd2);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q     <= '0;
      skid_q     <= '0;
      occ_q      <= 2'd0;
      in_ready_q <= 1'b1;
    end else begin
      head_q     <= head_d;
      skid_q     <= skid_d;
      occ_q      <= occ_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign occupancy      = occ_q;
  assign out_valid      = (occ_q != 2'd0);
  assign out_mem_data   = head_q.mem_data;
  assign out_alu_result = head_q.alu_result;
  assign out_reg_dest   = head_q.reg_dest;
  assign out_reg_write  = head_q.reg_write;
  assign out_mem_to_reg = head_q.mem_to_reg;
  assign wb_data        = head_q.mem_to_reg ? head_q.mem_data : head_q.alu_result;

endmodule
